// File: rtl/uart_rx_cfg_pkg.sv
// uart_rx_cfg_pkg: parity and FSM state encodings shared by the configurable UART blocks
package uart_rx_cfg_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_e;
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam int MIN_DBITS = 5;
   function automatic logic [3:0] clamp_bits(input logic [3:0] b, input int max_bits);
      return (int'(b) < MIN_DBITS) ? 4'(MIN_DBITS) : (int'(b) > max_bits) ? 4'(max_bits) : b;
   endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversampling tick, one tick every TIMER_FINAL_VALUE+1 clocks
module uart_baud_gen #(
   parameter int TIMER_BITS = 11
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [TIMER_BITS-1:0] TIMER_FINAL_VALUE,
   output logic                  tick
);
   logic [TIMER_BITS-1:0] cnt_q, cnt_d;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   // >= keeps the counter bounded if the terminal value is lowered at runtime
   always_comb begin
      tick  = cnt_q == TIMER_FINAL_VALUE;
      cnt_d = (cnt_q >= TIMER_FINAL_VALUE) ? '0 : cnt_q + 1'b1;
   end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5..DBITS data, N/E/O parity, 1/2 stop)
// with parity/framing/break/overrun detection and a one-entry valid/ready holding register.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int DBITS      = 8,
   parameter int SB_TICK    = 16,
   parameter int TIMER_BITS = 11
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [TIMER_BITS-1:0] TIMER_FINAL_VALUE,
   input  logic                  rx,
   input  logic [3:0]            cfg_data_bits,
   input  logic [1:0]            cfg_parity,
   input  logic                  cfg_stop2,
   output logic [DBITS-1:0]      rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  rx_perr,
   output logic                  rx_ferr,
   output logic                  rx_break,
   output logic                  rx_overrun,
   output logic                  rx_busy
);
   localparam int SW = $clog2(SB_TICK);
   state_e state_q, state_d;
   logic [1:0] sync_q, sync_d;
   logic [SW-1:0] s_q, s_d;
   logic [3:0] n_q, n_d, nb_q, nb_d;
   logic [1:0] par_q, par_d;
   logic [DBITS-1:0] sh_q, sh_d, hdata_q, hdata_d;
   logic stop2_q, stop2_d, sn_q, sn_d, ones_q, ones_d, perr_q, perr_d, ferr_q, ferr_d;
   logic brk_q, brk_d, done_q, done_d, valid_q, valid_d, ovr_q, ovr_d;
   logic hperr_q, hperr_d, hferr_q, hferr_d, hbrk_q, hbrk_d;
   logic tick, rxs, mid, smp, load;
   uart_baud_gen #(.TIMER_BITS(TIMER_BITS)) u_baud (
      .clk(clk), .reset(reset), .TIMER_FINAL_VALUE(TIMER_FINAL_VALUE), .tick(tick)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         s_q     <= '0;
         n_q     <= '0;
         nb_q    <= '0;
         par_q   <= PAR_NONE;
         stop2_q <= 1'b0;
         sn_q    <= 1'b0;
         sh_q    <= '0;
         ones_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         hdata_q <= '0;
         hperr_q <= 1'b0;
         hferr_q <= 1'b0;
         hbrk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         s_q     <= s_d;
         n_q     <= n_d;
         nb_q    <= nb_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         sn_q    <= sn_d;
         sh_q    <= sh_d;
         ones_q  <= ones_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         brk_q   <= brk_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         hdata_q <= hdata_d;
         hperr_q <= hperr_d;
         hferr_q <= hferr_d;
         hbrk_q  <= hbrk_d;
      end
   always_comb begin
      sync_d  = {sync_q[0], rx};
      rxs     = sync_q[1];
      mid     = tick && (s_q == SW'(SB_TICK/2-1));
      smp     = tick && (s_q == SW'(SB_TICK-1));
      state_d = state_q;
      s_d     = tick ? s_q + 1'b1 : s_q;
      n_d     = n_q;
      nb_d    = nb_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      sn_d    = sn_q;
      sh_d    = sh_q;
      ones_d  = ones_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      brk_d   = brk_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (!rxs) begin
            state_d = START;
            s_d     = '0;
            nb_d    = clamp_bits(cfg_data_bits, DBITS);
            par_d   = (cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD) ? cfg_parity : PAR_NONE;
            stop2_d = cfg_stop2;
         end
         START: if (mid) begin
            state_d = rxs ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
            sn_d    = 1'b0;
            sh_d    = '0;
            ones_d  = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            brk_d   = 1'b0;
         end
         DATA: if (smp) begin
            s_d    = '0;
            n_d    = n_q + 1'b1;
            ones_d = ones_q | rxs;
            for (int i = 0; i < DBITS; i++) sh_d[i] = (n_q == 4'(i)) ? rxs : sh_q[i];
            if (n_q == nb_q - 4'd1) state_d = (par_q != PAR_NONE) ? PARITY : STOP;
         end
         PARITY: if (smp) begin
            state_d = STOP;
            s_d     = '0;
            ones_d  = ones_q | rxs;
            perr_d  = ((^sh_q) ^ rxs) != (par_q == PAR_ODD);
         end
         STOP: if (smp) begin
            s_d    = '0;
            ones_d = ones_q | rxs;
            ferr_d = ferr_q | !rxs;
            if (stop2_q && !sn_q) sn_d = 1'b1;
            else begin
               // break = every bit of the frame low; park until the line returns high
               done_d  = 1'b1;
               brk_d   = !(ones_q | rxs);
               state_d = (ones_q | rxs) ? IDLE : BRKWAIT;
            end
         end
         BRKWAIT: if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      load    = done_q && (!valid_q || rx_ready);
      valid_d = load || (valid_q && !rx_ready);
      ovr_d   = done_q && !load;
      hdata_d = load ? sh_q : hdata_q;
      hperr_d = load ? perr_q : hperr_q;
      hferr_d = load ? ferr_q : hferr_q;
      hbrk_d  = load ? brk_q : hbrk_q;
   end
   always_comb begin
      rx_busy    = state_q != IDLE;
      rx_data    = hdata_q;
      rx_valid   = valid_q;
      rx_perr    = hperr_q;
      rx_ferr    = hferr_q;
      rx_break   = hbrk_q;
      rx_overrun = ovr_q;
   end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames with a queue-based scoreboard; TIMER_FINAL_VALUE=4 gives 80 clk/bit
module tb_uart_rx_cfg;
   typedef struct packed {logic [7:0] d; logic p; logic f; logic b;} frm_t;
   logic clk = 1'b0, reset = 1'b1, rx = 1'b1, rx_ready = 1'b1, cfg_stop2 = 1'b0;
   logic [10:0] tfv = 11'd4;
   logic [3:0] cfg_data_bits = 4'd8;
   logic [1:0] cfg_parity = 2'b00;
   logic [7:0] rx_data;
   logic rx_valid, rx_perr, rx_ferr, rx_break, rx_overrun, rx_busy;
   frm_t exp_q[$];
   int checks = 0, errors = 0, ovr_cnt = 0, pops = 0;

   always #5 clk = ~clk;

   uart_rx_cfg dut (
      .clk(clk), .reset(reset), .TIMER_FINAL_VALUE(tfv), .rx(rx),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_perr(rx_perr),
      .rx_ferr(rx_ferr), .rx_break(rx_break), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bit_out(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // a low stop bit is cut short so the line is back high before a new start can be seen
   task automatic tx_frame(input logic [7:0] d, input int nb, input int par, input logic stop_v,
                           input int nstop);
      bit_out(1'b0, 80);
      for (int i = 0; i < nb; i++) bit_out(d[i], 80);
      if (par >= 0) bit_out(par[0], 80);
      for (int i = 0; i < nstop; i++) bit_out(stop_v, stop_v ? 80 : 50);
      bit_out(1'b1, 80);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 rx_ready = v;
   endtask

   initial forever begin
      @(negedge clk);
      if (!reset && rx_overrun) ovr_cnt++;
      if (!reset && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none", {rx_data, rx_perr, rx_ferr, rx_break});
         end else begin
            check("frame", {rx_data, rx_perr, rx_ferr, rx_break}, exp_q.pop_front());
            pops++;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", {rx_data, rx_valid, rx_perr, rx_ferr, rx_break, rx_overrun, rx_busy}, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      // 1: 8N1 clean frame
      exp_q.push_back({8'h3F, 3'b000});
      tx_frame(8'h3F, 8, -1, 1'b1, 1);
      check("t1_frames", pops, 1);
      check("t1_busy", rx_busy, 0);
      // 2: 7E2, good then bad parity
      cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
      exp_q.push_back({8'h55, 3'b000});
      tx_frame(8'h55, 7, 0, 1'b1, 2);
      exp_q.push_back({8'h55, 3'b100});
      tx_frame(8'h55, 7, 1, 1'b1, 2);
      check("t2_frames", pops, 3);
      // 3: framing error, then break
      cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      exp_q.push_back({8'hA5, 3'b010});
      tx_frame(8'hA5, 8, -1, 1'b0, 1);
      bit_out(1'b1, 160);
      exp_q.push_back({8'h00, 3'b011});
      bit_out(1'b0, 1600);
      check("t3_brk_busy", rx_busy, 1);
      check("t3_brk_frames", pops, 5);
      bit_out(1'b1, 160);
      check("t3_after_busy", rx_busy, 0);
      // 4: 3-tick glitch, then 0x81 with an over-range bit count clamped to 8
      bit_out(1'b0, 15);
      bit_out(1'b1, 160);
      check("t4_glitch_busy", rx_busy, 0);
      check("t4_glitch_frames", pops, 5);
      cfg_data_bits = 4'd15;
      exp_q.push_back({8'h81, 3'b000});
      tx_frame(8'h81, 8, -1, 1'b1, 1);
      check("t4_frames", pops, 6);
      // 5: overrun
      set_ready(1'b0);
      exp_q.push_back({8'h11, 3'b000});
      tx_frame(8'h11, 8, -1, 1'b1, 1);
      tx_frame(8'h22, 8, -1, 1'b1, 1);
      check("t5_overrun_cnt", ovr_cnt, 1);
      check("t5_valid_held", rx_valid, 1);
      check("t5_data_held", rx_data, 8'h11);
      set_ready(1'b1);
      repeat (2) @(negedge clk);
      check("t5_frames", pops, 7);
      check("t5_valid_clr", rx_valid, 0);
      // 6: async reset during data bit 3
      bit_out(1'b0, 80);
      for (int i = 0; i < 3; i++) bit_out(1'b1, 80);
      bit_out(1'b1, 20);
      reset = 1'b1;
      #1;
      check("t6_reset_outputs", {rx_data, rx_valid, rx_perr, rx_ferr, rx_break, rx_overrun, rx_busy}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      exp_q.push_back({8'hC3, 3'b000});
      tx_frame(8'hC3, 8, -1, 1'b1, 1);
      check("t6_frames", pops, 8);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_overrun_cnt", ovr_cnt, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
